// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step and fetch-queue entry type for the fetch stage.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bundle of imem request/response, redirect and decode handshakes.
interface fetch_if;
    import fetch_pkg::*;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;
    modport master (
        output imem_req_valid, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_req_valid, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of in-flight fetches; slots are allocated at request,
// filled in order by responses and popped from the head.
module fetch_queue import fetch_pkg::*; #(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [ILEN-1:0] fill_instr_i,
    input  logic            pop_i,
    output logic [XLEN-1:0] head_pc_o,
    output logic [ILEN-1:0] head_instr_o,
    output logic            head_ready_o,
    output logic [CW-1:0]   alloc_cnt_o,
    output logic [CW-1:0]   unfilled_o
);
    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q, fill_idx;
    logic [CW-1:0] cnt_q, unf_q;
    // Unfilled slots are always the youngest ones, so the oldest sits unf_q behind the tail.
    assign fill_idx     = tail_q - PW'(unf_q);
    assign head_pc_o    = mem_q[head_q].pc;
    assign head_instr_o = mem_q[head_q].instr;
    assign head_ready_o = (cnt_q != '0) & mem_q[head_q].filled;
    assign alloc_cnt_o  = cnt_q;
    assign unfilled_o   = unf_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            unf_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            unf_q  <= '0;
        end else begin
            if (alloc_i) begin
                mem_q[tail_q] <= '{pc: alloc_pc_i, instr: '0, filled: 1'b0};
                tail_q        <= tail_q + 1'b1;
            end
            if (fill_i) begin
                mem_q[fill_idx].instr  <= fill_instr_i;
                mem_q[fill_idx].filled <= 1'b1;
            end
            if (pop_i) head_q <= head_q + 1'b1;
            cnt_q <= cnt_q + CW'(alloc_i) - CW'(pop_i);
            unf_q <= unf_q + CW'(alloc_i) - CW'(fill_i);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and in-order instruction fetch with redirect flush.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit import fetch_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic       clk,
    input  logic       reset,
    fetch_if.master    bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(2 * DEPTH + 1);
    logic [XLEN-1:0] pc_q, pc_d, head_pc;
    logic [ILEN-1:0] head_instr;
    logic [DW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   alloc_cnt, unfilled;
    logic            redirect, accept, pop, fill, head_ready;
    assign redirect           = bus.redirect_valid;
    assign bus.imem_req_valid = ~reset & (alloc_cnt < CW'(DEPTH)) & ~redirect;
    assign bus.imem_addr      = pc_q;
    assign accept             = bus.imem_req_valid & bus.imem_req_ready;
    assign bus.out_valid      = head_ready & ~redirect;
    assign pop                = bus.out_valid & bus.out_ready;
    assign fill               = bus.imem_rsp_valid & ~redirect & (drop_q == '0) & (unfilled != '0);
    assign bus.out_instr      = bus.out_valid ? head_instr : '0;
    assign bus.out_pc         = bus.out_valid ? head_pc : '0;
    assign bus.out_pc_plus4   = bus.out_valid ? head_pc + PC_STEP : '0;
    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (redirect),
        .alloc_i      (accept),
        .alloc_pc_i   (pc_q),
        .fill_i       (fill),
        .fill_instr_i (bus.imem_rsp_data),
        .pop_i        (pop),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr),
        .head_ready_o (head_ready),
        .alloc_cnt_o  (alloc_cnt),
        .unfilled_o   (unfilled)
    );
    // Responses still owed for flushed slots are counted and swallowed later.
    always_comb begin
        pc_d   = redirect ? bus.redirect_pc & ~32'h3 : accept ? pc_q + PC_STEP : pc_q;
        drop_d = redirect ? drop_q + DW'(unfilled) - DW'(bus.imem_rsp_valid)
               : (bus.imem_rsp_valid && drop_q != '0) ? drop_q - 1'b1 : drop_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop);
            perf_stall   <= perf_stall + 32'(~bus.out_valid);
        end
    end
`endif
endmodule
